// File: rtl/loop_nest_sequencer_if.sv
// rtl/loop_nest_sequencer_if.sv - index tuple stream between loop sequencer and tile datapath
interface loop_nest_sequencer_if #(
    parameter int OW = 3,
    parameter int IW = 5
);
    logic          idx_valid;
    logic          idx_ready;
    logic [OW-1:0] outer_idx;
    logic [IW-1:0] inner_idx;
    logic          first_inner;
    logic          last_inner;
    logic          last_all;

    modport master (
        output idx_valid, outer_idx, inner_idx, first_inner, last_inner, last_all,
        input  idx_ready
    );

    modport slave (
        input  idx_valid, outer_idx, inner_idx, first_inner, last_inner, last_all,
        output idx_ready
    );
endinterface

// File: rtl/loop_nest_sequencer.sv
// rtl/loop_nest_sequencer.sv - two-level outer x inner index sequencer with first/last flags
// Optional backpressure counter enabled by defining LOOP_SEQ_STALL_CNT_EN.
module loop_nest_sequencer #(
    parameter int OUTER_MAX = 7,
    parameter int INNER_MAX = 31,
    parameter int STALL_W   = 16,
    localparam int OW = $clog2(OUTER_MAX + 1),
    localparam int IW = $clog2(INNER_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [OW-1:0]          cfg_outer_last_i,
    input  logic [IW-1:0]          cfg_inner_last_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [STALL_W-1:0]     stall_cycles_o,
    loop_nest_sequencer_if.master  idx_if
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [OW-1:0] OUTER_MAX_V = OW'(OUTER_MAX);
    localparam logic [IW-1:0] INNER_MAX_V = IW'(INNER_MAX);

    state_t        state_q, state_d;
    logic [OW-1:0] outer_q, outer_d, outer_last_q, outer_last_d, outer_cfg_c;
    logic [IW-1:0] inner_q, inner_d, inner_last_q, inner_last_d, inner_cfg_c;
    logic          last_inner_c, last_all_c, beat_c, accept_c;

    // Clamp only exists when the index width can express values above MAX.
    if (OUTER_MAX == (1 << OW) - 1) begin : g_outer_full
        assign outer_cfg_c = cfg_outer_last_i;
    end else begin : g_outer_clamp
        assign outer_cfg_c = (cfg_outer_last_i > OUTER_MAX_V) ? OUTER_MAX_V : cfg_outer_last_i;
    end

    if (INNER_MAX == (1 << IW) - 1) begin : g_inner_full
        assign inner_cfg_c = cfg_inner_last_i;
    end else begin : g_inner_clamp
        assign inner_cfg_c = (cfg_inner_last_i > INNER_MAX_V) ? INNER_MAX_V : cfg_inner_last_i;
    end

    assign last_inner_c = (inner_q == inner_last_q);
    assign last_all_c   = last_inner_c && (outer_q == outer_last_q);
    assign beat_c       = (state_q == S_RUN) && idx_if.idx_ready;
    assign accept_c     = (state_q == S_IDLE) && start_i && !abort_i;

    assign idx_if.idx_valid   = (state_q == S_RUN);
    assign idx_if.outer_idx   = outer_q;
    assign idx_if.inner_idx   = inner_q;
    assign idx_if.first_inner = (inner_q == '0);
    assign idx_if.last_inner  = last_inner_c;
    assign idx_if.last_all    = last_all_c;
    assign busy_o             = (state_q != S_IDLE);
    assign done_o             = (state_q == S_DONE);

    always_comb begin
        state_d      = state_q;
        outer_d      = outer_q;
        inner_d      = inner_q;
        outer_last_d = outer_last_q;
        inner_last_d = inner_last_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d      = S_RUN;
                    outer_last_d = outer_cfg_c;
                    inner_last_d = inner_cfg_c;
                    outer_d      = '0;
                    inner_d      = '0;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (beat_c) begin
                    if (last_all_c) begin
                        state_d = S_DONE;
                    end else if (last_inner_c) begin
                        inner_d = '0;
                        outer_d = outer_q + OW'(1);
                    end else begin
                        inner_d = inner_q + IW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            outer_q      <= '0;
            inner_q      <= '0;
            outer_last_q <= '0;
            inner_last_q <= '0;
        end else begin
            state_q      <= state_d;
            outer_q      <= outer_d;
            inner_q      <= inner_d;
            outer_last_q <= outer_last_d;
            inner_last_q <= inner_last_d;
        end
    end

`ifdef LOOP_SEQ_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    // Saturating count of RUN cycles where the consumer withheld ready.
    always_comb begin
        stall_d = stall_q;
        if (accept_c) begin
            stall_d = '0;
        end else if ((state_q == S_RUN) && !idx_if.idx_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif
endmodule
